// File: rtl/pack_pkg.sv
// Shared video-pack definitions for the pack pipeline stages.
package pack_pkg;

  localparam int unsigned PACK_W = 50;
  localparam int unsigned X_W    = 12;
  localparam int unsigned Y_W    = 11;
  localparam int unsigned RGB_W  = 24;

  typedef struct packed {
    logic             vs;
    logic             hs;
    logic             de;
    logic [RGB_W-1:0] rgb;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
  } video_pack_t;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } xhair_state_e;

endpackage

// File: rtl/pack_crosshair_if.sv
// Pack/target bundle for the crosshair overlay stage.
interface pack_crosshair_if;
  import pack_pkg::*;

  video_pack_t    i_pack;
  logic           i_tgt_valid;
  logic [X_W-1:0] i_tgt_x;
  logic [Y_W-1:0] i_tgt_y;
  video_pack_t    o_pack;
  logic           o_locked;

  // Upstream driver / downstream observer side.
  modport master (
    output i_pack, i_tgt_valid, i_tgt_x, i_tgt_y,
    input  o_pack, o_locked
  );

  // Overlay stage side.
  modport slave (
    input  i_pack, i_tgt_valid, i_tgt_x, i_tgt_y,
    output o_pack, o_locked
  );

endinterface

// File: rtl/pack_frame_tick.sv
// Frame-start detector: one-cycle strobe on a rising edge of vs.
module pack_frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vs,
  output logic tick
);

  logic vs_q;

  // vs history; cleared on reset so a high vs right after reset counts as a tick.
  always_ff @(posedge clk) begin
    if (rst) vs_q <= 1'b0;
    else     vs_q <= vs;
  end

  assign tick = vs & ~vs_q;

endmodule

// File: rtl/pack_crosshair.sv
// Crosshair overlay stage: draws a crosshair at the latest detector target,
// committing new targets only at frame starts and dropping the lock after
// LOST_FRAMES frames without a target. Output is the overlaid pack, 1 clk late.
// Optional: define PACK_CROSSHAIR_BLINK_EN to blink the crosshair once the
// target is half-way stale.
module pack_crosshair
  import pack_pkg::*;
#(
  parameter int unsigned      ARM_LEN     = 16,
  parameter int unsigned      THICK       = 1,
  parameter logic [RGB_W-1:0] COLOR       = 24'hFF0000,
  parameter int unsigned      LOST_FRAMES = 30
) (
  input logic             clk,
  input logic             rst,
  pack_crosshair_if.slave bus
);

  localparam logic [12:0] ArmLim   = 13'(ARM_LEN);
  localparam logic [12:0] ThickLim = 13'(THICK);
  localparam logic [7:0]  LostCnt  = 8'(LOST_FRAMES);

  xhair_state_e   state_q, state_d;
  logic           pend_q, pend_d;
  logic [X_W-1:0] pend_x_q, pend_x_d, act_x_q, act_x_d;
  logic [Y_W-1:0] pend_y_q, pend_y_d, act_y_q, act_y_d;
  logic [7:0]     cnt_q, cnt_d;
  video_pack_t    out_q, ovl;
  logic           tick;

  pack_frame_tick u_frame_tick (
    .clk  (clk),
    .rst  (rst),
    .vs   (bus.i_pack.vs),
    .tick (tick)
  );

  // State, target and miss-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pend_q   <= 1'b0;
      pend_x_q <= '0;
      pend_y_q <= '0;
      act_x_q  <= '0;
      act_y_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      act_x_q  <= act_x_d;
      act_y_q  <= act_y_d;
      cnt_q    <= cnt_d;
    end
  end

  // Target capture, frame-boundary commit and loss counting.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    act_x_d  = act_x_q;
    act_y_d  = act_y_q;
    cnt_d    = cnt_q;

    if (bus.i_tgt_valid) begin
      pend_d   = 1'b1;
      pend_x_d = bus.i_tgt_x;
      pend_y_d = bus.i_tgt_y;
    end

    if (tick) begin
      if (bus.i_tgt_valid) begin
        // A strobe on the tick itself wins and skips the pending stage.
        act_x_d = bus.i_tgt_x;
        act_y_d = bus.i_tgt_y;
        pend_d  = 1'b0;
        cnt_d   = '0;
        state_d = StLocked;
      end else if (pend_q) begin
        act_x_d = pend_x_q;
        act_y_d = pend_y_q;
        pend_d  = 1'b0;
        cnt_d   = '0;
        state_d = StLocked;
      end else if (state_q == StLocked) begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_d == LostCnt) state_d = StIdle;
      end
    end
  end

  logic signed [12:0] dx, dy;
  logic        [12:0] adx, ady;
  logic               on_arm, blink_on;

`ifdef PACK_CROSSHAIR_BLINK_EN
  localparam logic [7:0] HalfCnt = 8'(LOST_FRAMES / 2);
  assign blink_on = (cnt_q < HalfCnt) || cnt_q[1];
`else
  assign blink_on = 1'b1;
`endif

  // Pixel hit test against the active coordinate; no wrap at screen edges.
  always_comb begin
    dx     = $signed({1'b0, bus.i_pack.x}) - $signed({1'b0, act_x_q});
    dy     = $signed({2'b00, bus.i_pack.y}) - $signed({2'b00, act_y_q});
    adx    = dx[12] ? 13'(-dx) : dx;
    ady    = dy[12] ? 13'(-dy) : dy;
    on_arm = ((adx <= ArmLim) && (ady < ThickLim)) ||
             ((ady <= ArmLim) && (adx < ThickLim));
    ovl    = bus.i_pack;
    if ((state_q == StLocked) && blink_on && bus.i_pack.de && on_arm) ovl.rgb = COLOR;
  end

  // One-cycle output register.
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= ovl;
  end

  assign bus.o_pack   = out_q;
  assign bus.o_locked = (state_q == StLocked);

endmodule

// File: doc/pack_crosshair.md
# pack_crosshair

Video-pack overlay stage that sits directly downstream of the pack selector. It consumes the selected 50-bit video pack, draws a crosshair at the most recent target coordinate reported by the detector, and forwards the pack one cycle later. Target updates take effect only at frame boundaries, so a frame never tears. The crosshair is withdrawn when no target arrives for a configurable number of frames.

## Interface
Parameters:
- ARM_LEN, 16, arm half-length in pixels, measured from the centre.
- THICK, 1, arm half-thickness; a pixel is on an arm when its distance from the arm axis is < THICK.
- COLOR, 24'hFF0000, RGB value written on crosshair pixels.
- LOST_FRAMES, 30, number of frames without a target before the crosshair is withdrawn (1..255).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- i_pack  in  50  video pack {vs[49], hs[48], de[47], rgb[46:23], x[22:11], y[10:0]}.
- i_tgt_valid  in  1  one-cycle strobe; target coordinate is valid.
- i_tgt_x  in  12  target column.
- i_tgt_y  in  11  target row.
- o_pack  out  50  overlaid pack, same layout as i_pack.
- o_locked  out  1  high while the crosshair is being drawn.

## Operation
- Target capture:
  - i_tgt_valid=1 loads i_tgt_x/i_tgt_y into the pending register and sets the pending flag.
  - Every strobe is accepted; a later strobe overwrites an earlier one.
- Frame tick: a rising edge of i_pack.vs (0 in the previous cycle, 1 now).
- FSM:
  - IDLE: no drawing. On a frame tick with pending=1 → commit pending to the active coordinate, clear pending and the frame counter, go to LOCKED.
  - LOCKED: on a frame tick with pending=1 → commit and clear the counter. On a frame tick with pending=0 → increment the 8-bit counter. If the counter reaches LOST_FRAMES → go to IDLE.
- Simultaneous strobe and frame tick: the strobe's coordinate is committed on that same tick. It bypasses pending and is not counted as a miss.
- Draw test, applied only when LOCKED and de=1:
  - dx = x − tx and dy = y − ty, computed as 13-bit signed values; |dx| and |dy| are taken as absolute values.
  - The pixel is drawn when (|dx| ≤ ARM_LEN and |dy| < THICK) or (|dy| ≤ ARM_LEN and |dx| < THICK).
  - Arms reaching past screen edges are clipped naturally; there is no wrap-around.
- Output fields:
  - A drawn pixel gets rgb = COLOR.
  - vs, hs, de, x and y are always passed through unchanged.
- o_locked: high when the FSM is in LOCKED.

## Timing
- o_pack = the overlaid i_pack, delayed by exactly 1 clk. The sync/de alignment of the pack is preserved.
- Commit timing: a committed coordinate applies from the cycle after the frame tick, i.e. the first cycle of the new frame.
- o_locked timing: changes in the cycle after the frame tick that caused the transition.
- Reset (rst high at a clk edge):
  - o_pack=0, o_locked=0, FSM=IDLE, pending=0, counter=0, vs history=0.
  - Reset asserted mid-frame blanks the output for one cycle; normal passthrough resumes the cycle after rst deasserts.
- Counter saturation: the counter never wraps, because reaching LOST_FRAMES exits LOCKED.

## Configuration
- PACK_CROSSHAIR_BLINK_EN defined:
  - While LOCKED with counter ≥ LOST_FRAMES/2, the crosshair is drawn only on frames where counter[1]=1. This gives a 2-on/2-off blink that warns of a stale target.
- PACK_CROSSHAIR_BLINK_EN undefined: the crosshair is drawn solidly throughout LOCKED.

## Structure
- Shared package pack_pkg holds:
  - typedef struct packed video_pack_t with the fields above.
  - Field-width constants PACK_W=50, X_W=12, Y_W=11, RGB_W=24.
- Sub-module pack_frame_tick:
  - Registers vs and outputs the one-cycle frame-tick strobe.
  - Reusable by other pack stages.
- Top level holds the FSM, pending/active registers, counter and output register.

## Test plan
- Passthrough: after reset with no target, a 64×32 test frame with rgb=24'h00FF00 → o_pack equals i_pack delayed 1 clk; o_locked stays 0.
- Lock and draw: strobe (40,20) mid-frame → no change in the current frame. From the next frame, pixels (24..56,20) and (40,4..36) read 24'hFF0000; pixel (40,37) is unchanged; o_locked=1.
- Simultaneous strobe and frame tick: strobe (10,10) in the same cycle as the vs rising edge → crosshair centred at (10,10) in that frame; counter=0.
- Loss: with LOST_FRAMES=3, lock, then send 3 frames with no strobe → o_locked falls the cycle after the 3rd tick; the 4th frame is unmodified.
- Edge clipping: target (0,0), ARM_LEN=16 → only x 0..16 on row 0 and y 0..16 on column 0 are drawn; no pixels appear at x≈4080.
- Mid-frame reset: assert rst for 1 cycle while LOCKED → o_pack=0 and o_locked=0 the next cycle. Passthrough resumes; a new strobe is needed to relock.
